// File: rtl/lcd_pkg.sv
// Opcodes, receiver states and reset constants shared by the
// 8080-bus command receiver and its window cursor.
package lcd_pkg;

   localparam logic [7:0] CMD_NOP     = 8'h00;
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;

   localparam logic [7:0] COLMOD_RST  = 8'h66;

   typedef enum logic [2:0] {
      IDLE,
      CASET_P,
      PASET_P,
      RAMWR_HI,
      RAMWR_LO,
      ONE_P,
      IGNORE
   } rx_state_t;

endpackage

// File: rtl/lcd_window_cursor.sv
// Column/page window bounds and the RAMWR write cursor that
// walks the window row by row, wrapping back to its origin.
module lcd_window_cursor
   import lcd_pkg::*;
#(
   parameter int H_RES   = 240,
   parameter int V_RES   = 320,
   parameter int COORD_W = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               srst,
   input  logic               load_col,
   input  logic               load_page,
   input  logic               start,
   input  logic               adv,
   input  logic [COORD_W-1:0] ld_s,
   input  logic [COORD_W-1:0] ld_e,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y,
   output logic               win_bad
);

   logic [COORD_W-1:0] sc, ec, sp, ep;

   assign win_bad = (sc > ec) || (sp > ep);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc    <= '0;
         sp    <= '0;
         ec    <= COORD_W'(H_RES - 1);
         ep    <= COORD_W'(V_RES - 1);
         cur_x <= '0;
         cur_y <= '0;
      end else if (srst) begin
         sc    <= '0;
         sp    <= '0;
         ec    <= COORD_W'(H_RES - 1);
         ep    <= COORD_W'(V_RES - 1);
         cur_x <= '0;
         cur_y <= '0;
      end else begin
         if (load_col) begin
            sc <= ld_s;
            ec <= ld_e;
         end
         if (load_page) begin
            sp <= ld_s;
            ep <= ld_e;
         end
         if (start) begin
            cur_x <= sc;
            cur_y <= sp;
         end else if (adv) begin
            if (cur_x == ec) begin
               cur_x <= sc;
               cur_y <= (cur_y == ep) ? sp : cur_y + 1'b1;
            end else begin
               cur_x <= cur_x + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_cmd_receiver.sv
// Display-side 8080 write-bus receiver: decodes commands and
// parameters and turns RAMWR byte pairs into RGB565 pixel writes.
module lcd_cmd_receiver
   import lcd_pkg::*;
#(
   parameter int H_RES   = 240,
   parameter int V_RES   = 320,
   parameter int COORD_W = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic               dcx,
   input  logic [7:0]         D,
   output logic               pix_we,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [15:0]        pix_data,
   output logic               disp_on,
   output logic               sleep,
   output logic [7:0]         colmod,
   output logic               cmd_err
);

   rx_state_t          state;
   logic               wr_q;
   logic               strobe, cmd_byte, dat_byte;
   logic [1:0]         cnt;
   logic [7:0]         hi_q;
   logic [COORD_W-1:0] s_tmp, word;
   logic               one_colmod;
   logic [7:0]         madctl;
   logic               unused_madctl;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic               win_bad, in_range;
   logic               load_col, load_page;
   logic               cur_start, cur_adv, srst;

   assign strobe    = wr & ~wr_q;
   assign cmd_byte  = strobe & ~dcx;
   assign dat_byte  = strobe & dcx;
   assign word      = COORD_W'({hi_q, D});
   assign in_range  = (cur_x < COORD_W'(H_RES)) &&
                      (cur_y < COORD_W'(V_RES));
   assign srst      = cmd_byte && (D == CMD_SWRESET);
   assign cur_start = cmd_byte && (D == CMD_RAMWR) && !win_bad;
   assign cur_adv   = dat_byte && (state == RAMWR_LO);
   assign load_col  = dat_byte && (state == CASET_P) && (cnt == 2'd3);
   assign load_page = dat_byte && (state == PASET_P) && (cnt == 2'd3);

   // MADCTL is accepted and kept but has no effect on addressing.
   assign unused_madctl = ^madctl;

   lcd_window_cursor #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .COORD_W (COORD_W)
   ) u_cursor (
      .clk       (clk),
      .rst       (rst),
      .srst      (srst),
      .load_col  (load_col),
      .load_page (load_page),
      .start     (cur_start),
      .adv       (cur_adv),
      .ld_s      (s_tmp),
      .ld_e      (word),
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .win_bad   (win_bad)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_q <= 1'b0;
      else     wr_q <= wr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         hi_q       <= '0;
         s_tmp      <= '0;
         one_colmod <= 1'b0;
         madctl     <= '0;
         pix_we     <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= '0;
         disp_on    <= 1'b0;
         sleep      <= 1'b1;
         colmod     <= COLMOD_RST;
         cmd_err    <= 1'b0;
      end else begin
         pix_we  <= 1'b0;
         cmd_err <= 1'b0;
         if (cmd_byte) begin
            cnt   <= '0;
            state <= IDLE;
            unique case (1'b1)
               (D == CMD_NOP): ;
               (D == CMD_SWRESET): begin
                  madctl   <= '0;
                  pix_x    <= '0;
                  pix_y    <= '0;
                  pix_data <= '0;
                  disp_on  <= 1'b0;
                  sleep    <= 1'b1;
                  colmod   <= COLMOD_RST;
               end
               (D == CMD_SLPOUT):  sleep   <= 1'b0;
               (D == CMD_DISPOFF): disp_on <= 1'b0;
               (D == CMD_DISPON):  disp_on <= 1'b1;
               (D == CMD_CASET):   state   <= CASET_P;
               (D == CMD_PASET):   state   <= PASET_P;
               (D == CMD_COLMOD): begin
                  state      <= ONE_P;
                  one_colmod <= 1'b1;
               end
               (D == CMD_MADCTL): begin
                  state      <= ONE_P;
                  one_colmod <= 1'b0;
               end
               (D == CMD_RAMWR): begin
                  if (win_bad) begin
                     cmd_err <= 1'b1;
                     state   <= IGNORE;
                  end else begin
                     state <= RAMWR_HI;
                  end
               end
               default: begin
                  cmd_err <= 1'b1;
                  state   <= IGNORE;
               end
            endcase
         end else if (dat_byte) begin
            case (state)
               CASET_P, PASET_P: begin
                  cnt <= cnt + 2'd1;
                  if (!cnt[0])       hi_q  <= D;
                  if (cnt == 2'd1)   s_tmp <= word;
                  if (cnt == 2'd3)   state <= IDLE;
               end
               ONE_P: begin
                  if (one_colmod) colmod <= D;
                  else            madctl <= D;
                  state <= IDLE;
               end
               RAMWR_HI: begin
                  hi_q  <= D;
                  state <= RAMWR_LO;
               end
               RAMWR_LO: begin
                  if (in_range) begin
                     pix_we   <= 1'b1;
                     pix_x    <= cur_x;
                     pix_y    <= cur_y;
                     pix_data <= {hi_q, D};
                  end
                  state <= RAMWR_HI;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_receiver.sv
// Directed bench for lcd_cmd_receiver: a byte/expectation table
// plus hand sequences for power-on and mid-pixel async reset.
module tb_lcd_cmd_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr  = 1'b0;
   logic        dcx = 1'b0;
   logic [7:0]  D   = 8'h00;
   logic        pix_we;
   logic [8:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic        disp_on, sleep, cmd_err;
   logic [7:0]  colmod;

   lcd_cmd_receiver dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .dcx      (dcx),
      .D        (D),
      .pix_we   (pix_we),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .pix_data (pix_data),
      .disp_on  (disp_on),
      .sleep    (sleep),
      .colmod   (colmod),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dcx;
      logic [7:0]  d;
      logic        we;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] data;
      logic        err;
      logic        sl;
      logic        dp;
      logic [7:0]  cm;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;
   int   dbl    = 0;
   logic we_prev = 1'b0;

   logic        cs = 1'b1, cd = 1'b0;
   logic [7:0]  cc = 8'h66;

   logic        s_we, s_err, s_sl, s_dp, s_we2, s_err2;
   logic [8:0]  s_x, s_y;
   logic [15:0] s_data;
   logic [7:0]  s_cm;

   always @(negedge clk) begin
      if (pix_we) begin
         we_cnt <= we_cnt + 1;
         if (we_prev) dbl <= dbl + 1;
      end
      we_prev <= pix_we;
   end

   function automatic void chk(input string name,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic vc(input logic c, input logic [7:0] b,
                     input logic err);
      vec_t t;
      t.dcx = c;   t.d = b;    t.we = 1'b0;
      t.x = '0;    t.y = '0;   t.data = '0;
      t.err = err; t.sl = cs;  t.dp = cd;  t.cm = cc;
      vecs.push_back(t);
   endtask

   task automatic vp(input logic [7:0] b, input logic [8:0] x,
                     input logic [8:0] y, input logic [15:0] data);
      vec_t t;
      t.dcx = 1'b1; t.d = b;    t.we = 1'b1;
      t.x = x;      t.y = y;    t.data = data;
      t.err = 1'b0; t.sl = cs;  t.dp = cd;  t.cm = cc;
      vecs.push_back(t);
   endtask

   task automatic send(input logic c, input logic [7:0] b);
      @(negedge clk);
      dcx = c; D = b; wr = 1'b1;
      @(negedge clk);
      s_we = pix_we;   s_err = cmd_err;
      s_x = pix_x;     s_y = pix_y;    s_data = pix_data;
      s_sl = sleep;    s_dp = disp_on; s_cm = colmod;
      wr = 1'b0;
      @(negedge clk);
      s_we2 = pix_we;  s_err2 = cmd_err;
   endtask

   task automatic send4(input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e,
                        input logic [7:0] f);
      send(1'b0, op);
      send(1'b1, a); send(1'b1, b); send(1'b1, e); send(1'b1, f);
   endtask

   initial begin
      // status commands and COLMOD
      cs = 1'b0; vc(0, 8'h11, 0);
      cd = 1'b1; vc(0, 8'h29, 0);
      cd = 1'b0; vc(0, 8'h28, 0);
      cd = 1'b1; vc(0, 8'h29, 0);
      vc(0, 8'h3A, 0);
      cc = 8'h55; vc(1, 8'h55, 0);
      vc(0, 8'h36, 0); vc(1, 8'hC0, 0);
      // 2x2 window at (2..3, 5..6), five pixels wrap to origin
      vc(0, 8'h2A, 0);
      vc(1, 8'h00, 0); vc(1, 8'h02, 0); vc(1, 8'h00, 0); vc(1, 8'h03, 0);
      vc(0, 8'h2B, 0);
      vc(1, 8'h00, 0); vc(1, 8'h05, 0); vc(1, 8'h00, 0); vc(1, 8'h06, 0);
      vc(0, 8'h2C, 0);
      vc(1, 8'hF8, 0); vp(8'h00, 9'd2, 9'd5, 16'hF800);
      vc(1, 8'h07, 0); vp(8'hE0, 9'd3, 9'd5, 16'h07E0);
      vc(1, 8'h00, 0); vp(8'h1F, 9'd2, 9'd6, 16'h001F);
      vc(1, 8'hFF, 0); vp(8'hFF, 9'd3, 9'd6, 16'hFFFF);
      vc(1, 8'hA5, 0); vp(8'h5A, 9'd2, 9'd5, 16'hA55A);
      // half pixel aborted by a command
      vc(0, 8'h2C, 0); vc(1, 8'hAB, 0); vc(0, 8'h00, 0);
      vc(0, 8'h2C, 0);
      vc(1, 8'h12, 0); vp(8'h34, 9'd2, 9'd5, 16'h1234);
      // columns beyond H_RES are never written
      vc(0, 8'h2A, 0);
      vc(1, 8'h00, 0); vc(1, 8'hFA, 0); vc(1, 8'h00, 0); vc(1, 8'hFB, 0);
      vc(0, 8'h2C, 0);
      vc(1, 8'h11, 0); vc(1, 8'h22, 0); vc(1, 8'h33, 0); vc(1, 8'h44, 0);
      // inverted window and unknown opcode
      vc(0, 8'h2A, 0);
      vc(1, 8'h00, 0); vc(1, 8'h09, 0); vc(1, 8'h00, 0); vc(1, 8'h03, 0);
      vc(0, 8'h2C, 1); vc(1, 8'h11, 0); vc(1, 8'h22, 0);
      vc(0, 8'hB1, 1);
      vc(1, 8'h01, 0); vc(1, 8'h02, 0); vc(1, 8'h03, 0);
      // SWRESET restores everything including the window
      cs = 1'b1; cd = 1'b0; cc = 8'h66; vc(0, 8'h01, 0);
      vc(0, 8'h2C, 0);
      vc(1, 8'hC3, 0); vp(8'h3C, 9'd0, 9'd0, 16'hC33C);
      vc(1, 8'h01, 0); vp(8'h02, 9'd1, 9'd0, 16'h0102);
      // truncated CASET leaves the window unchanged
      vc(0, 8'h2A, 0);
      vc(1, 8'h00, 0); vc(1, 8'h07, 0); vc(1, 8'h00, 0);
      vc(0, 8'h2C, 0);
      vc(1, 8'hAA, 0); vp(8'hBB, 9'd0, 9'd0, 16'hAABB);
      vc(1, 8'hCC, 0); vp(8'hDD, 9'd1, 9'd0, 16'hCCDD);

      // power-on reset and idle bus
      repeat (3) @(negedge clk);
      chk("rst pix_we", {31'd0, pix_we}, 32'd0);
      chk("rst cmd_err", {31'd0, cmd_err}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle sleep", {31'd0, sleep}, 32'd1);
      chk("idle disp_on", {31'd0, disp_on}, 32'd0);
      chk("idle colmod", {24'd0, colmod}, 32'h66);
      chk("idle pix_x", {23'd0, pix_x}, 32'd0);
      chk("idle pix_y", {23'd0, pix_y}, 32'd0);
      chk("idle pix_data", {16'd0, pix_data}, 32'd0);
      chk("idle we count", we_cnt, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i].dcx, vecs[i].d);
         chk($sformatf("v%0d pix_we", i), {31'd0, s_we}, {31'd0, vecs[i].we});
         chk($sformatf("v%0d cmd_err", i), {31'd0, s_err}, {31'd0, vecs[i].err});
         chk($sformatf("v%0d we width", i), {31'd0, s_we2}, 32'd0);
         chk($sformatf("v%0d err width", i), {31'd0, s_err2}, 32'd0);
         chk($sformatf("v%0d sleep", i), {31'd0, s_sl}, {31'd0, vecs[i].sl});
         chk($sformatf("v%0d disp_on", i), {31'd0, s_dp}, {31'd0, vecs[i].dp});
         chk($sformatf("v%0d colmod", i), {24'd0, s_cm}, {24'd0, vecs[i].cm});
         if (vecs[i].we) begin
            chk($sformatf("v%0d pix_x", i), {23'd0, s_x}, {23'd0, vecs[i].x});
            chk($sformatf("v%0d pix_y", i), {23'd0, s_y}, {23'd0, vecs[i].y});
            chk($sformatf("v%0d pix_data", i), {16'd0, s_data},
                {16'd0, vecs[i].data});
         end
      end

      // async reset between hi and lo byte of a pixel
      send(1'b0, 8'h11);
      send(1'b0, 8'h29);
      send4(8'h2A, 8'h00, 8'h04, 8'h00, 8'h07);
      send4(8'h2B, 8'h00, 8'h03, 8'h00, 8'h03);
      send(1'b0, 8'h2C);
      send(1'b1, 8'h12);
      send(1'b1, 8'h34);
      chk("pre-rst pix_x", {23'd0, s_x}, 32'd4);
      chk("pre-rst pix_y", {23'd0, s_y}, 32'd3);
      send(1'b1, 8'h55);
      #3 rst = 1'b1;
      #1;
      chk("arst sleep", {31'd0, sleep}, 32'd1);
      chk("arst disp_on", {31'd0, disp_on}, 32'd0);
      chk("arst colmod", {24'd0, colmod}, 32'h66);
      chk("arst pix_x", {23'd0, pix_x}, 32'd0);
      chk("arst pix_y", {23'd0, pix_y}, 32'd0);
      chk("arst pix_data", {16'd0, pix_data}, 32'd0);
      chk("arst pix_we", {31'd0, pix_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(1'b1, 8'h66);
      chk("post-rst data ignored", {31'd0, s_we}, 32'd0);
      send(1'b0, 8'h2C);
      send(1'b1, 8'h9A);
      chk("post-rst hi no we", {31'd0, s_we}, 32'd0);
      send(1'b1, 8'hBC);
      chk("post-rst pix_we", {31'd0, s_we}, 32'd1);
      chk("post-rst pix_x", {23'd0, s_x}, 32'd0);
      chk("post-rst pix_y", {23'd0, s_y}, 32'd0);
      chk("post-rst pix_data", {16'd0, s_data}, 32'h9ABC);

      repeat (2) @(negedge clk);
      chk("total writes", we_cnt, 32'd12);
      chk("double pulses", dbl, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
